line_fill_merge: RTL and testbench

LINE_FILL_MERGE -- requirements
Module: line_fill_merge

---
 rtl/lc3b_types.sv | 21 ++
 rtl/word_merge.sv | 22 ++
 rtl/line_fill_merge.sv | 148 ++++++++++++++
 tb/tb_line_fill_merge.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared types for the line fill/merge block: FSM state encoding and
// default-width line, word and byte-mask typedefs.
package lc3b_types;

  localparam int DEF_LINE_BITS = 128;
  localparam int DEF_WORD_BITS = 16;
  localparam int DEF_BEAT_BITS = 64;
  localparam int DEF_MASK_BITS = DEF_WORD_BITS / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    MERGE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [DEF_LINE_BITS-1:0] line_t;
  typedef logic [DEF_WORD_BITS-1:0] word_t;
  typedef logic [DEF_MASK_BITS-1:0] mask_t;

endpackage

// File: rtl/word_merge.sv
// Byte-masked word merge: each set mask bit takes that byte from the new
// word, every other byte keeps the old value.
module word_merge #(
  parameter  int WORD_BITS = 16,
  localparam int MASK_BITS = WORD_BITS / 8
) (
  input  logic [WORD_BITS-1:0] old_word_i,
  input  logic [WORD_BITS-1:0] new_word_i,
  input  logic [MASK_BITS-1:0] mask_i,
  output logic [WORD_BITS-1:0] merged_o
);

  always_comb begin
    merged_o = old_word_i;
    for (int b = 0; b < MASK_BITS; b++) begin
      if (mask_i[b]) begin
        merged_o[b*8 +: 8] = new_word_i[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/line_fill_merge.sv
// Cache line fill/merge engine: fills a line from pmem (miss) or takes way_data
// (hit), then applies a byte-masked store. Macro CRITICAL_WORD_FIRST_EN starts fills at the target beat.
module line_fill_merge
  import lc3b_types::*;
#(
  parameter  int LINE_BITS = 128,
  parameter  int WORD_BITS = 16,
  parameter  int BEAT_BITS = 64,
  localparam int WORDS     = LINE_BITS / WORD_BITS,
  localparam int MASK_BITS = WORD_BITS / 8,
  localparam int BEATS     = LINE_BITS / BEAT_BITS,
  localparam int OFF_W     = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int BEAT_AW   = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hit,
  input  logic                 write,
  input  logic [OFF_W-1:0]     offset,
  input  logic [WORD_BITS-1:0] mem_wdata,
  input  logic [MASK_BITS-1:0] byte_enable,
  input  logic [LINE_BITS-1:0] way_data,
  input  logic [BEAT_BITS-1:0] pmem_rdata,
  input  logic                 pmem_rvalid,
  output logic [BEAT_AW-1:0]   beat_addr,
  output logic                 busy,
  output logic                 done,
  output logic [LINE_BITS-1:0] out,
  output logic                 crit_valid,
  output logic [WORD_BITS-1:0] crit_word,
  output logic [1:0]           state_dbg_o
);

  state_e               state_q;
  logic [LINE_BITS-1:0] line_q;
  logic [BEAT_AW-1:0]   beat_ptr_q;
  logic [BEAT_AW-1:0]   beat_cnt_q;
  logic [OFF_W-1:0]     offset_q;
  logic [WORD_BITS-1:0] wdata_q;
  logic [MASK_BITS-1:0] be_q;
  logic                 write_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 crit_q;

  logic [BEAT_AW-1:0]   start_beat_d;
  logic [BEAT_AW-1:0]   target_beat;
  logic [BEAT_AW-1:0]   beat_ptr_d;
  logic [WORD_BITS-1:0] cur_word;
  logic [WORD_BITS-1:0] merged_word;
  logic [MASK_BITS-1:0] eff_mask;

`ifdef CRITICAL_WORD_FIRST_EN
  // Fetch the beat holding the requested word first; the rest wrap around.
  assign start_beat_d = BEAT_AW'((int'(offset) * WORD_BITS) / BEAT_BITS);
`else
  assign start_beat_d = '0;
`endif

  assign target_beat = BEAT_AW'((int'(offset_q) * WORD_BITS) / BEAT_BITS);
  assign beat_ptr_d  = (beat_ptr_q == BEAT_AW'(BEATS - 1)) ? '0 : beat_ptr_q + 1'b1;

  assign cur_word = line_q[offset_q*WORD_BITS +: WORD_BITS];
  assign eff_mask = write_q ? be_q : '0;

  word_merge #(
    .WORD_BITS (WORD_BITS)
  ) u_word_merge (
    .old_word_i (cur_word),
    .new_word_i (wdata_q),
    .mask_i     (eff_mask),
    .merged_o   (merged_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      line_q     <= '0;
      beat_ptr_q <= '0;
      beat_cnt_q <= '0;
      offset_q   <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crit_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            offset_q <= offset;
            wdata_q  <= mem_wdata;
            be_q     <= byte_enable;
            write_q  <= write;
            busy_q   <= 1'b1;
            if (hit) begin
              line_q  <= way_data;
              crit_q  <= 1'b1;
              state_q <= MERGE;
            end else begin
              beat_ptr_q <= start_beat_d;
              beat_cnt_q <= '0;
              state_q    <= FILL;
            end
          end
        end
        FILL: begin
          if (pmem_rvalid) begin
            line_q[beat_ptr_q*BEAT_BITS +: BEAT_BITS] <= pmem_rdata;
            beat_ptr_q <= beat_ptr_d;
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_ptr_q == target_beat) begin
              crit_q <= 1'b1;
            end
            if (beat_cnt_q == BEAT_AW'(BEATS - 1)) begin
              crit_q  <= 1'b1;
              state_q <= MERGE;
            end
          end
        end
        MERGE: begin
          line_q[offset_q*WORD_BITS +: WORD_BITS] <= merged_word;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          crit_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // crit_word re-merges in DONE too; the merge is idempotent on the stored word.
  assign crit_word   = crit_q ? merged_word : '0;
  assign crit_valid  = crit_q;
  assign out         = line_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign beat_addr   = beat_ptr_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_line_fill_merge.sv
// Randomized scoreboard bench for line_fill_merge: drivers push expected
// lines, a negedge monitor pops and compares on every done.
module tb_line_fill_merge;

  localparam int LINE_BITS = 128;
  localparam int WORD_BITS = 16;
  localparam int BEAT_BITS = 64;
  localparam int BEATS     = LINE_BITS / BEAT_BITS;
  localparam int WPB       = BEAT_BITS / WORD_BITS;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 hit = 1'b0;
  logic                 write = 1'b0;
  logic [2:0]           offset = '0;
  logic [15:0]          mem_wdata = '0;
  logic [1:0]           byte_enable = '0;
  logic [127:0]         way_data = '0;
  logic [63:0]          pmem_rdata = '0;
  logic                 pmem_rvalid = 1'b0;
  logic [0:0]           beat_addr;
  logic                 busy;
  logic                 done;
  logic [127:0]         out;
  logic                 crit_valid;
  logic [15:0]          crit_word;
  logic [1:0]           state_dbg_o;

  int checks = 0;
  int errors = 0;
  logic [143:0] exp_q[$];
  logic [127:0] model_line = '0;

  line_fill_merge dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .hit         (hit),
    .write       (write),
    .offset      (offset),
    .mem_wdata   (mem_wdata),
    .byte_enable (byte_enable),
    .way_data    (way_data),
    .pmem_rdata  (pmem_rdata),
    .pmem_rvalid (pmem_rvalid),
    .beat_addr   (beat_addr),
    .busy        (busy),
    .done        (done),
    .out         (out),
    .crit_valid  (crit_valid),
    .crit_word   (crit_word),
    .state_dbg_o (state_dbg_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] apply_store(input logic [127:0] line, input int off,
                                               input logic [15:0] wd, input logic [1:0] be,
                                               input logic wr);
    logic [127:0] r;
    r = line;
    if (wr) begin
      for (int b = 0; b < 2; b++) begin
        if (be[b]) r[off*16 + b*8 +: 8] = wd[b*8 +: 8];
      end
    end
    return r;
  endfunction

  function automatic int start_beat_of(input int off);
`ifdef CRITICAL_WORD_FIRST_EN
    return off / WPB;
`else
    return 0;
`endif
  endfunction

  function automatic logic [143:0] pack_exp(input logic [127:0] line, input int off);
    logic [15:0] w;
    w = line[off*16 +: 16];
    return {w, line};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_hit(input logic [127:0] wl, input int off, input logic [15:0] wd,
                        input logic [1:0] be, input logic wr);
    logic [127:0] exp;
    exp = apply_store(wl, off, wd, be, wr);
    exp_q.push_back(pack_exp(exp, off));
    model_line = exp;
    start = 1'b1; hit = 1'b1; way_data = wl; offset = off[2:0];
    mem_wdata = wd; byte_enable = be; write = wr;
    @(posedge clk); #1;
    start = 1'b0;
    way_data = {$urandom, $urandom, $urandom, $urandom};
    mem_wdata = 16'($urandom);
    chk("hit_merge_busy", busy, 1);
    chk("hit_merge_crit", crit_valid, 1);
    chk("hit_merge_done", done, 0);
    @(posedge clk); #1;
    chk("hit_done_lat", done, 1);
    @(posedge clk); #1;
    chk("hit_idle_busy", busy, 0);
    chk("hit_idle_done", done, 0);
  endtask

  task automatic do_miss(input int off, input logic [15:0] wd, input logic [1:0] be,
                         input logic wr, input logic [63:0] b0, input logic [63:0] b1,
                         input int gaps_max);
    logic [127:0] exp;
    logic [63:0]  beats[2];
    int sb, tgt, slot;
    logic seen;
    beats[0] = b0; beats[1] = b1;
    sb = start_beat_of(off);
    tgt = off / WPB;
    exp = model_line;
    for (int k = 0; k < BEATS; k++) exp[((sb + k) % BEATS)*64 +: 64] = beats[k];
    exp = apply_store(exp, off, wd, be, wr);
    exp_q.push_back(pack_exp(exp, off));
    model_line = exp;
    start = 1'b1; hit = 1'b0; offset = off[2:0];
    mem_wdata = wd; byte_enable = be; write = wr;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      slot = (sb + k) % BEATS;
      repeat ($urandom_range(0, gaps_max)) begin
        // A start pulse mid-fill must be ignored.
        start = 1'($urandom_range(0, 1));
        hit = 1'($urandom_range(0, 1));
        way_data = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        start = 1'b0;
        chk("fill_busy", busy, 1);
      end
      chk("beat_addr", beat_addr, slot);
      chk("crit_before_beat", crit_valid, seen);
      pmem_rvalid = 1'b1;
      pmem_rdata = beats[k];
      @(posedge clk); #1;
      pmem_rvalid = 1'b0;
      pmem_rdata = {$urandom, $urandom};
      if (slot == tgt) seen = 1'b1;
    end
    chk("miss_merge_crit", crit_valid, 1);
    chk("miss_merge_done", done, 0);
    @(posedge clk); #1;
    chk("miss_done_lat", done, 1);
    @(posedge clk); #1;
    chk("miss_idle_busy", busy, 0);
  endtask

  task automatic stray_beat();
    pmem_rvalid = 1'b1;
    pmem_rdata = {$urandom, $urandom};
    @(posedge clk); #1;
    pmem_rvalid = 1'b0;
    chk("stray_busy", busy, 0);
    chk("stray_out", out, model_line);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done required=no_done");
      end else begin
        logic [143:0] e;
        e = exp_q.pop_front();
        chk("done_line", out, e[127:0]);
        chk("done_crit_word", crit_word, 128'(e[143:128]));
        chk("done_crit_valid", crit_valid, 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_crit_valid", crit_valid, 0);
    chk("rst_crit_word", crit_word, 0);
    chk("rst_beat_addr", beat_addr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_hit('0, 3, 16'hBEEF, 2'b11, 1'b1);
    chk("hit_write_line", out, {64'h0, 16'hBEEF, 48'h0});

    do_hit({8{16'hFFFF}}, 0, 16'h1234, 2'b01, 1'b1);
    chk("hit_partial_word0", out[15:0], 16'hFF34);

    stray_beat();

`ifdef CRITICAL_WORD_FIRST_EN
    do_miss(6, 16'h0, 2'b00, 1'b0, 64'hAAAA_1111_2222_3333, 64'hBBBB_4444_5555_6666, 0);
    chk("cwf_line", out, {64'hAAAA_1111_2222_3333, 64'hBBBB_4444_5555_6666});
`else
    do_miss(7, 16'hA5A5, 2'b10, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h1122_3344_5566_7788, 0);
    chk("miss_byte1", out[127:120], 8'hA5);
    chk("miss_byte0", out[119:112], 8'h22);
`endif

    // Reset mid-fill, colliding with start and a beat.
    start = 1'b1; hit = 1'b0; offset = 3'd2; write = 1'b1; byte_enable = 2'b11;
    @(posedge clk); #1;
    start = 1'b0;
    pmem_rvalid = 1'b1; pmem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; hit = 1'b1; pmem_rvalid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; pmem_rvalid = 1'b0;
    model_line = '0;
    chk("midrst_busy", busy, 0);
    chk("midrst_out", out, 0);
    chk("midrst_beat_addr", beat_addr, 0);
    chk("midrst_crit_valid", crit_valid, 0);
    chk("midrst_crit_word", crit_word, 0);
    chk("midrst_done", done, 0);
    stray_beat();
    do_hit({$urandom, $urandom, $urandom, $urandom}, 5, 16'h5A5A, 2'b10, 1'b1);

    for (int i = 0; i < 40; i++) begin
      int off;
      logic [15:0] wd;
      logic [1:0] be;
      logic wr;
      off = $urandom_range(0, 7);
      wd = 16'($urandom);
      be = 2'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
        do_hit({$urandom, $urandom, $urandom, $urandom}, off, wd, be, wr);
      else
        do_miss(off, wd, be, wr, {$urandom, $urandom}, {$urandom, $urandom}, 2);
      if ($urandom_range(0, 3) == 0) stray_beat();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
